rf_cap_dm_sequencer: RTL and testbench
======================================

// Module: rf_cap_dm_sequencer
// PURPOSE
//  Sequences one ADC-capture or DAC-playback transfer through an AXI DataMover channel (S2MM or MM2S).
//  - Takes start address, capture size and start/reset from the RFSOC register block.
//  - Splits the transfer into <=CHUNK_BYTES DataMover commands, one outstanding at a time.
//  - Checks every status beat and reports progress, errors and completion back to the register block.
// PARAMETERS
//  ADDR_WIDTH   32        byte-address width of cfg_start_addr / current_addr
//  BTT_WIDTH    23        DataMover BTT field width
//  CHUNK_BYTES  32'h10_0000  max bytes per command; power of 2, < 2**BTT_WIDTH
//  BEAT_BYTES   64        stream beat size; cap_size is truncated to a multiple of this
// PORTS
//  clk              in   1   single clock
//  rst_n            in   1   asynchronous active-low reset
//  cfg_start_addr   in   32  transfer base byte address, sampled on start
//  cfg_cap_size     in   32  transfer length in bytes, sampled on start
//  cfg_start        in   1   one-cycle start pulse
//  cfg_reset        in   1   synchronous soft abort/clear, level
//  m_cmd_tdata      out  72  DataMover command
//  m_cmd_tvalid     out  1   command valid
//  m_cmd_tready     in   1   command ready
//  s_sts_tdata      in   8   DataMover status {OKAY,SLVERR,DECERR,INTERR,TAG[3:0]}
//  s_sts_tvalid     in   1   status valid
//  s_sts_tready     out  1   status ready
//  dm_status        out  8   last status beat accepted
//  current_addr     out  32  start + bytes completed
//  run_cycles       out  8   completed passes, saturating at 255
//  mm_err           out  1   sticky error flag
//  cap_done         out  1   one-cycle pulse at completion
//  busy             out  1   FSM not in IDLE/DONE/ERR
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE.
//  States: IDLE, CMD, STS, DONE, ERR, DRAIN.
//  IDLE: on cfg_start, latch addr, size&~(BEAT_BYTES-1) -> remaining; chunk idx=0.
//   - remaining==0 -> DONE, no command issued.
//   - else -> CMD; m_cmd_tvalid rises the next cycle.
//  Command fields:
//   - BTT = min(remaining, CHUNK_BYTES); [23] Type=1 (INCR); DSA=0.
//   - EOF[30] = 1 only on the last chunk; SADDR[63:32] = base + done bytes.
//   - TAG[67:64] = chunk idx[3:0]; [71:68] = 0.
//  CMD: tvalid held, tdata stable until tready. Handshake -> STS.
//  STS: s_sts_tready=1 only in STS and DRAIN. On beat, latch dm_status.
//   - OK = OKAY & ~|[6:4] & TAG==idx[3:0].
//   - OK: current_addr += BTT; remaining -= BTT; idx++.
//   - remaining==0 -> DONE, else -> CMD.
//   - not OK: mm_err=1 -> ERR; no further commands.
//  DONE: cap_done pulses 1 cycle; run_cycles++ (saturates at 255); -> IDLE.
//  ERR: holds until cfg_reset, which clears mm_err and goes to IDLE.
//  Abort: cfg_reset in CMD before handshake -> IDLE, deasserts tvalid.
//   - Documented AXI exception: tvalid may drop before handshake on abort.
//  Drain: cfg_reset in STS -> DRAIN; consume exactly one status beat, no checks, no counter update -> IDLE.
//  cfg_reset in IDLE/DONE also clears run_cycles, current_addr and dm_status.
//  cfg_start outside IDLE is ignored. cfg_start with cfg_reset in the same cycle: reset wins.
//  Arithmetic: 32-bit addresses wrap modulo 2**32 with no error.
//   - Status beats arriving outside STS/DRAIN are not accepted (tready=0).
// CONFIGURATION
//  RF_CAP_LOOP_EN defined: adds input cfg_loop (1 bit).
//   - In DONE with cfg_loop=1: pulse cap_done, increment run_cycles.
//   - Then reload the latched base/size, idx=0, -> CMD (continuous playback/capture).
//   - cfg_loop=0 or cfg_reset ends the loop.
//  RF_CAP_LOOP_EN undefined: no cfg_loop port; one-shot only.
// STRUCTURE
//  Package rfsoc_dm_pkg:
//   - dm_cmd_t packed struct (72b); dm_sts_t packed struct (8b).
//   - seq_state_e enum; DM_TYPE_INCR constant.
//  Sub-module rf_dm_cmd_pack: combinational {addr,btt,eof,tag} -> dm_cmd_t formatter, shared with the DAC MM2S instance.
// TESTING
//  - Base case: start 0x1000_0000, size 0x30_0000; sts 0x80|tag each.
//    -> 3 cmds BTT 0x10_0000 at 0x1000_0000/0x1010_0000/0x1020_0000, tags 0/1/2, EOF on 3rd only.
//    -> cap_done 1 pulse; run_cycles=1; current_addr=0x1030_0000.
//  - Odd size: 0x18_0047 -> 2 cmds, BTT 0x10_0000 then 0x08_0040.
//  - Zero size: 0x3F -> no tvalid; cap_done pulse 2 cycles after start; busy stays 0.
//  - Error: 2nd status = 0xC1 (SLVERR).
//    -> mm_err=1, dm_status=0xC1, FSM in ERR, no 3rd cmd.
//    -> cfg_reset clears to IDLE, mm_err=0.
//  - Backpressure and abort:
//    -> tready low 20 cycles: tdata/tvalid stable.
//    -> cfg_reset during STS: one status beat drained, then IDLE, no new cmd.
//  - Loop (RF_CAP_LOOP_EN), cfg_loop=1, size 0x10_0000:
//    -> run_cycles reaches 3 after 3 passes, all at base addr.
//    -> drop cfg_loop: FSM returns to IDLE after the current pass.

Source files
------------

// File: rtl/rfsoc_dm_pkg.sv
// rfsoc_dm_pkg: DataMover command/status layouts and sequencer state encoding
package rfsoc_dm_pkg;
  localparam logic DM_TYPE_INCR = 1'b1;
  typedef struct packed {
    logic [3:0]  rsvd;
    logic [3:0]  tag;
    logic [31:0] saddr;
    logic        drr;
    logic        eof;
    logic [5:0]  dsa;
    logic        typ;
    logic [22:0] btt;
  } dm_cmd_t;
  typedef struct packed {
    logic       okay;
    logic       slverr;
    logic       decerr;
    logic       interr;
    logic [3:0] tag;
  } dm_sts_t;
  typedef enum logic [2:0] {S_IDLE, S_CMD, S_STS, S_DONE, S_ERR, S_DRAIN} seq_state_e;
endpackage

// File: rtl/rf_dm_cmd_pack.sv
// rf_dm_cmd_pack: formats {addr,btt,eof,tag} into a 72-bit DataMover command word
module rf_dm_cmd_pack
  import rfsoc_dm_pkg::*;
(
  input  logic [31:0] addr_i,
  input  logic [22:0] btt_i,
  input  logic        eof_i,
  input  logic [3:0]  tag_i,
  output logic [71:0] cmd_o
);
  dm_cmd_t c;
  always_comb begin
    c       = '0;
    c.tag   = tag_i;
    c.saddr = addr_i;
    c.eof   = eof_i;
    c.typ   = DM_TYPE_INCR;
    c.btt   = btt_i;
  end
  assign cmd_o = c;
endmodule

// File: rtl/rf_cap_dm_sequencer.sv
// rf_cap_dm_sequencer: splits one capture/playback transfer into chunked DataMover commands.
// Define RF_CAP_LOOP_EN to add cfg_loop for continuous back-to-back passes.
module rf_cap_dm_sequencer
  import rfsoc_dm_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 32,
  parameter int          BTT_WIDTH   = 23,
  parameter logic [31:0] CHUNK_BYTES = 32'h10_0000,
  parameter int          BEAT_BYTES  = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] cfg_start_addr,
  input  logic [31:0]           cfg_cap_size,
  input  logic                  cfg_start,
  input  logic                  cfg_reset,
`ifdef RF_CAP_LOOP_EN
  input  logic                  cfg_loop,
`endif
  output logic [71:0]           m_cmd_tdata,
  output logic                  m_cmd_tvalid,
  input  logic                  m_cmd_tready,
  input  logic [7:0]            s_sts_tdata,
  input  logic                  s_sts_tvalid,
  output logic                  s_sts_tready,
  output logic [7:0]            dm_status,
  output logic [ADDR_WIDTH-1:0] current_addr,
  output logic [7:0]            run_cycles,
  output logic                  mm_err,
  output logic                  cap_done,
  output logic                  busy
);
  localparam logic [31:0] BEAT_MASK = ~(32'(BEAT_BYTES) - 32'd1);
  seq_state_e            state_q;
  logic [31:0]           remaining_q;
  logic [3:0]            idx_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            status_q, runs_q;
  logic                  err_q, done_q;
`ifdef RF_CAP_LOOP_EN
  logic [ADDR_WIDTH-1:0] base_q;
  logic [31:0]           size_q;
`endif
  logic [31:0]          cap_bytes;
  logic                 eof;
  logic [BTT_WIDTH-1:0] btt;
  logic [71:0]          cmd;
  dm_sts_t              sts;
  logic                 sts_ok;
  assign cap_bytes = cfg_cap_size & BEAT_MASK;
  assign eof       = remaining_q <= CHUNK_BYTES;
  assign btt       = eof ? remaining_q[BTT_WIDTH-1:0] : CHUNK_BYTES[BTT_WIDTH-1:0];
  assign sts       = dm_sts_t'(s_sts_tdata);
  assign sts_ok    = sts.okay & ~(sts.slverr | sts.decerr | sts.interr) & (sts.tag == idx_q);
  rf_dm_cmd_pack u_pack (
    .addr_i(addr_q),
    .btt_i (btt),
    .eof_i (eof),
    .tag_i (idx_q),
    .cmd_o (cmd)
  );
  assign m_cmd_tvalid = state_q == S_CMD;
  assign m_cmd_tdata  = m_cmd_tvalid ? cmd : '0;
  assign s_sts_tready = state_q == S_STS || state_q == S_DRAIN;
  assign busy         = state_q == S_CMD || state_q == S_STS || state_q == S_DRAIN;
  assign dm_status    = status_q;
  assign current_addr = addr_q;
  assign run_cycles   = runs_q;
  assign mm_err       = err_q;
  assign cap_done     = done_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      idx_q       <= '0;
      addr_q      <= '0;
      status_q    <= '0;
      runs_q      <= '0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
`ifdef RF_CAP_LOOP_EN
      base_q      <= '0;
      size_q      <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE:
          if (cfg_reset) begin
            runs_q   <= '0;
            addr_q   <= '0;
            status_q <= '0;
          end else if (cfg_start) begin
            addr_q      <= cfg_start_addr;
            remaining_q <= cap_bytes;
            idx_q       <= '0;
`ifdef RF_CAP_LOOP_EN
            base_q      <= cfg_start_addr;
            size_q      <= cap_bytes;
`endif
            state_q     <= cap_bytes == '0 ? S_DONE : S_CMD;
          end
        S_CMD:
          if (cfg_reset) state_q <= S_IDLE;
          else if (m_cmd_tready) state_q <= S_STS;
        S_STS:
          // a beat arriving alongside the abort is itself the drained beat
          if (cfg_reset) state_q <= s_sts_tvalid ? S_IDLE : S_DRAIN;
          else if (s_sts_tvalid) begin
            status_q <= s_sts_tdata;
            if (sts_ok) begin
              addr_q      <= addr_q + ADDR_WIDTH'(btt);
              remaining_q <= remaining_q - 32'(btt);
              idx_q       <= idx_q + 4'd1;
              state_q     <= eof ? S_DONE : S_CMD;
            end else begin
              err_q   <= 1'b1;
              state_q <= S_ERR;
            end
          end
        S_DONE:
          if (cfg_reset) begin
            runs_q   <= '0;
            addr_q   <= '0;
            status_q <= '0;
            state_q  <= S_IDLE;
          end else begin
            done_q  <= 1'b1;
            runs_q  <= runs_q + {7'd0, runs_q != 8'hff};
            state_q <= S_IDLE;
`ifdef RF_CAP_LOOP_EN
            if (cfg_loop && size_q != '0) begin
              addr_q      <= base_q;
              remaining_q <= size_q;
              idx_q       <= '0;
              state_q     <= S_CMD;
            end
`endif
          end
        S_ERR:
          if (cfg_reset) begin
            err_q   <= 1'b0;
            state_q <= S_IDLE;
          end
        S_DRAIN:
          if (s_sts_tvalid) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rf_cap_dm_sequencer.sv
// tb_rf_cap_dm_sequencer: directed scenarios for the DataMover transfer sequencer
module tb_rf_cap_dm_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] cfg_start_addr = '0;
  logic [31:0] cfg_cap_size = '0;
  logic        cfg_start = 1'b0;
  logic        cfg_reset = 1'b0;
  logic        cfg_loop = 1'b0;
  logic [71:0] m_cmd_tdata;
  logic        m_cmd_tvalid;
  logic        m_cmd_tready = 1'b0;
  logic [7:0]  s_sts_tdata = '0;
  logic        s_sts_tvalid = 1'b0;
  logic        s_sts_tready;
  logic [7:0]  dm_status;
  logic [31:0] current_addr;
  logic [7:0]  run_cycles;
  logic        mm_err, cap_done, busy;
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  rf_cap_dm_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_start_addr(cfg_start_addr), .cfg_cap_size(cfg_cap_size),
    .cfg_start(cfg_start), .cfg_reset(cfg_reset),
`ifdef RF_CAP_LOOP_EN
    .cfg_loop(cfg_loop),
`endif
    .m_cmd_tdata(m_cmd_tdata), .m_cmd_tvalid(m_cmd_tvalid), .m_cmd_tready(m_cmd_tready),
    .s_sts_tdata(s_sts_tdata), .s_sts_tvalid(s_sts_tvalid), .s_sts_tready(s_sts_tready),
    .dm_status(dm_status), .current_addr(current_addr), .run_cycles(run_cycles),
    .mm_err(mm_err), .cap_done(cap_done), .busy(busy)
  );

  function automatic logic [71:0] exp_cmd(logic [31:0] a, logic [22:0] b, logic e, logic [3:0] t);
    return {4'h0, t, a, 1'b0, e, 6'd0, 1'b1, b};
  endfunction

  task automatic start(input logic [31:0] a, input logic [31:0] s);
    cfg_start_addr = a;
    cfg_cap_size = s;
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
  endtask

  task automatic pulse_reset();
    cfg_reset = 1'b1;
    @(negedge clk);
    cfg_reset = 1'b0;
  endtask

  // Waits for a command, checks it, handshakes it and answers with one status beat
  task automatic run_chunk(input string nm, input logic [31:0] a, input logic [22:0] b, input logic e, input logic [3:0] t, input logic [7:0] st);
    for (int i = 0; i < 50 && !m_cmd_tvalid; i++) @(negedge clk);
    vectors++;
    if (m_cmd_tvalid !== 1'b1) begin
      miscompares++;
      $display("FAIL %s tvalid timeout: got %b want 1", nm, m_cmd_tvalid);
    end
    vectors++;
    if (m_cmd_tdata !== exp_cmd(a, b, e, t)) begin
      miscompares++;
      $display("FAIL %s tdata: got %h want %h", nm, m_cmd_tdata, exp_cmd(a, b, e, t));
    end
    m_cmd_tready = 1'b1;
    @(negedge clk);
    m_cmd_tready = 1'b0;
    vectors++;
    if (s_sts_tready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s sts_tready: got %b want 1", nm, s_sts_tready);
    end
    s_sts_tdata = st;
    s_sts_tvalid = 1'b1;
    @(negedge clk);
    s_sts_tvalid = 1'b0;
  endtask

  task automatic expect_no_cmd(input string nm, input int n);
    logic seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      seen |= m_cmd_tvalid;
      @(negedge clk);
    end
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++;
      $display("FAIL %s unexpected tvalid: got 1 want 0", nm);
    end
  endtask

  task automatic expect_done(input string nm, input logic [7:0] runs, input logic [31:0] addr);
    vectors++;
    if (cap_done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s pre-done: cap_done %b busy %b want 0 0", nm, cap_done, busy);
    end
    @(negedge clk);
    vectors++;
    if (cap_done !== 1'b1 || run_cycles !== runs || current_addr !== addr) begin
      miscompares++;
      $display("FAIL %s done: cap_done %b runs %0d addr %h want 1 %0d %h", nm, cap_done, run_cycles, current_addr, runs, addr);
    end
    @(negedge clk);
    vectors++;
    if (cap_done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s post-done: cap_done %b busy %b want 0 0", nm, cap_done, busy);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    vectors++;
    if ({m_cmd_tdata, m_cmd_tvalid, s_sts_tready, dm_status, current_addr, run_cycles, mm_err, cap_done, busy} !== '0) begin
      miscompares++;
      $display("FAIL reset outputs: tvalid %b tdata %h addr %h runs %0d busy %b want all 0", m_cmd_tvalid, m_cmd_tdata, current_addr, run_cycles, busy);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_base();
    start(32'h1000_0000, 32'h30_0000);
    run_chunk("base0", 32'h1000_0000, 23'h10_0000, 1'b0, 4'd0, 8'h80);
    run_chunk("base1", 32'h1010_0000, 23'h10_0000, 1'b0, 4'd1, 8'h81);
    run_chunk("base2", 32'h1020_0000, 23'h10_0000, 1'b1, 4'd2, 8'h82);
    expect_done("base", 8'd1, 32'h1030_0000);
  endtask

  task automatic test_odd_size();
    start(32'h0000_0000, 32'h18_0047);
    run_chunk("odd0", 32'h0000_0000, 23'h10_0000, 1'b0, 4'd0, 8'h80);
    run_chunk("odd1", 32'h0010_0000, 23'h08_0040, 1'b1, 4'd1, 8'h81);
    expect_done("odd", 8'd2, 32'h0018_0040);
  endtask

  task automatic test_zero_size();
    start(32'h0700_0000, 32'h0000_003F);
    vectors++;
    if (m_cmd_tvalid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL zero start: tvalid %b busy %b want 0 0", m_cmd_tvalid, busy);
    end
    expect_done("zero", 8'd3, 32'h0700_0000);
  endtask

  task automatic test_error();
    start(32'h2000_0000, 32'h30_0000);
    run_chunk("err0", 32'h2000_0000, 23'h10_0000, 1'b0, 4'd0, 8'h80);
    run_chunk("err1", 32'h2010_0000, 23'h10_0000, 1'b0, 4'd1, 8'hC1);
    vectors++;
    if (mm_err !== 1'b1 || dm_status !== 8'hC1 || busy !== 1'b0 || current_addr !== 32'h2010_0000) begin
      miscompares++;
      $display("FAIL err state: mm_err %b sts %h busy %b addr %h want 1 c1 0 20100000", mm_err, dm_status, busy, current_addr);
    end
    expect_no_cmd("err hold", 10);
    vectors++;
    if (mm_err !== 1'b1) begin
      miscompares++;
      $display("FAIL err sticky: got %b want 1", mm_err);
    end
    pulse_reset();
    vectors++;
    if (mm_err !== 1'b0 || busy !== 1'b0 || run_cycles !== 8'd3) begin
      miscompares++;
      $display("FAIL err clear: mm_err %b busy %b runs %0d want 0 0 3", mm_err, busy, run_cycles);
    end
    pulse_reset();
    vectors++;
    if (run_cycles !== 8'd0 || current_addr !== 32'd0 || dm_status !== 8'd0) begin
      miscompares++;
      $display("FAIL idle clear: runs %0d addr %h sts %h want 0 0 0", run_cycles, current_addr, dm_status);
    end
  endtask

  task automatic test_backpressure_abort();
    logic bad = 1'b0;
    start(32'h3000_0000, 32'h20_0000);
    for (int i = 0; i < 20; i++) begin
      bad |= (m_cmd_tvalid !== 1'b1) || (m_cmd_tdata !== exp_cmd(32'h3000_0000, 23'h10_0000, 1'b0, 4'd0));
      if (i == 5) begin
        cfg_start_addr = 32'h7700_0000;
        cfg_start = 1'b1;
      end
      @(negedge clk);
      cfg_start = 1'b0;
    end
    vectors++;
    if (bad !== 1'b0) begin
      miscompares++;
      $display("FAIL backpressure: tdata/tvalid unstable, got %h want %h", m_cmd_tdata, exp_cmd(32'h3000_0000, 23'h10_0000, 1'b0, 4'd0));
    end
    m_cmd_tready = 1'b1;
    @(negedge clk);
    m_cmd_tready = 1'b0;
    pulse_reset();
    vectors++;
    if (busy !== 1'b1 || s_sts_tready !== 1'b1) begin
      miscompares++;
      $display("FAIL drain wait: busy %b sts_tready %b want 1 1", busy, s_sts_tready);
    end
    s_sts_tdata = 8'h45;
    s_sts_tvalid = 1'b1;
    @(negedge clk);
    s_sts_tvalid = 1'b0;
    vectors++;
    if (busy !== 1'b0 || s_sts_tready !== 1'b0 || mm_err !== 1'b0 || current_addr !== 32'h3000_0000) begin
      miscompares++;
      $display("FAIL drain end: busy %b rdy %b mm_err %b addr %h want 0 0 0 30000000", busy, s_sts_tready, mm_err, current_addr);
    end
    expect_no_cmd("drain idle", 10);
    start(32'h5000_0000, 32'h0000_0040);
    vectors++;
    if (m_cmd_tdata !== exp_cmd(32'h5000_0000, 23'h40, 1'b1, 4'd0)) begin
      miscompares++;
      $display("FAIL abort cmd: got %h want %h", m_cmd_tdata, exp_cmd(32'h5000_0000, 23'h40, 1'b1, 4'd0));
    end
    pulse_reset();
    vectors++;
    if (m_cmd_tvalid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL abort: tvalid %b busy %b want 0 0", m_cmd_tvalid, busy);
    end
  endtask

  task automatic test_start_with_reset();
    cfg_reset = 1'b1;
    start(32'h6000_0000, 32'h0000_1000);
    cfg_reset = 1'b0;
    vectors++;
    if (m_cmd_tvalid !== 1'b0 || busy !== 1'b0 || current_addr !== 32'd0) begin
      miscompares++;
      $display("FAIL start+reset: tvalid %b busy %b addr %h want 0 0 0", m_cmd_tvalid, busy, current_addr);
    end
    expect_no_cmd("start+reset idle", 5);
  endtask

`ifdef RF_CAP_LOOP_EN
  task automatic test_loop();
    cfg_loop = 1'b1;
    start(32'h4000_0000, 32'h10_0000);
    run_chunk("loop0", 32'h4000_0000, 23'h10_0000, 1'b1, 4'd0, 8'h80);
    run_chunk("loop1", 32'h4000_0000, 23'h10_0000, 1'b1, 4'd0, 8'h80);
    run_chunk("loop2", 32'h4000_0000, 23'h10_0000, 1'b1, 4'd0, 8'h80);
    cfg_loop = 1'b0;
    expect_done("loop", 8'd3, 32'h4010_0000);
    expect_no_cmd("loop end", 10);
  endtask
`endif

  initial begin
    test_reset();
    test_base();
    test_odd_size();
    test_zero_size();
    test_error();
    test_backpressure_abort();
    test_start_with_reset();
`ifdef RF_CAP_LOOP_EN
    test_loop();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
